rat_path_player: RTL and testbench

//  Consumer at the far end of the solved-path queue: after the solver has queued its move list,

---
 rtl/rat_pkg.sv | 30 +++
 rtl/rat_path_player_if.sv | 36 +++
 rtl/rat_move_step.sv | 37 +++
 rtl/rat_path_player.sv | 167 ++++++++++++++++
 tb/tb_rat_path_player.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rat_pkg.sv
// Shared types for the rat maze path player and its solver: move encoding,
// fault codes and the replay state machine states.
package rat_pkg;

  typedef enum logic [1:0] {
    MV_RIGHT = 2'b00,
    MV_DOWN  = 2'b01,
    MV_LEFT  = 2'b10,
    MV_UP    = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_WALL = 2'b01,
    ERR_OOB  = 2'b10,
    ERR_DRY  = 2'b11
  } err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_VERIFY,
    ST_PACE,
    ST_DRAIN,
    ST_DONE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/rat_path_player_if.sv
// Bundle between the path player and its environment: solved-path queue read
// port, maze-memory read port and the replay status outputs.
interface rat_path_player_if #(
  parameter int CW = 4
);
  // Queue is first-word fall-through: q_out is valid whenever q_empty=0, and
  // the head is consumed on any cycle where dequeue=1 (dequeue implies !q_empty).
  logic          run;
  logic [1:0]    q_out;
  logic          q_empty;
  logic          dequeue;
  logic          mem_rd;
  logic [CW-1:0] mem_x;
  logic [CW-1:0] mem_y;
  logic          mem_d;
  logic [CW-1:0] pos_x;
  logic [CW-1:0] pos_y;
  logic          step_valid;
  logic          busy;
  logic          arrived;
  logic          err;
  logic [1:0]    err_code;

  modport master (
    input  run, q_out, q_empty, mem_d,
    output dequeue, mem_rd, mem_x, mem_y, pos_x, pos_y,
           step_valid, busy, arrived, err, err_code
  );

  modport slave (
    output run, q_out, q_empty, mem_d,
    input  dequeue, mem_rd, mem_x, mem_y, pos_x, pos_y,
           step_valid, busy, arrived, err, err_code
  );

endinterface

// File: rtl/rat_move_step.sv
// Combinational single-move stepper: applies a 2-bit move to (x,y) and flags
// any step that leaves the 2**CW x 2**CW grid.
module rat_move_step
  import rat_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  move_t         move_i,
  output logic [CW-1:0] nx_o,
  output logic [CW-1:0] ny_o,
  output logic          oob_o
);

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic [CW:0] sx;
  logic [CW:0] sy;

  // One extra bit catches both overflow past 2**CW-1 and underflow below 0.
  always_comb begin
    sx = {1'b0, x_i};
    sy = {1'b0, y_i};
    unique case (move_i)
      MV_RIGHT: sx = {1'b0, x_i} + ONE;
      MV_DOWN:  sy = {1'b0, y_i} + ONE;
      MV_LEFT:  sx = {1'b0, x_i} - ONE;
      MV_UP:    sy = {1'b0, y_i} - ONE;
    endcase
  end

  assign nx_o  = sx[CW-1:0];
  assign ny_o  = sy[CW-1:0];
  assign oob_o = sx[CW] | sy[CW];

endmodule

// File: rtl/rat_path_player.sv
// Replays the solved move list from (0,0), paced by STEP_DIV, reporting goal
// arrival or the first fault. RAT_PLAYER_WALLCHK_EN adds a maze-memory wall re-check per move.
module rat_path_player
  import rat_pkg::*;
#(
  parameter int CW       = 4,
  parameter int GOAL_X   = 15,
  parameter int GOAL_Y   = 15,
  parameter int STEP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  rat_path_player_if.master bus,
  output state_t            dbg_state_o
);

  localparam logic [CW-1:0] GX       = CW'(GOAL_X);
  localparam logic [CW-1:0] GY       = CW'(GOAL_Y);
  localparam logic [7:0]    DIV_LAST = 8'(STEP_DIV - 1);
  localparam state_t        ST_AFTER = (STEP_DIV == 0) ? ST_FETCH : ST_PACE;

  state_t        state_q;
  logic [CW-1:0] pos_x_q;
  logic [CW-1:0] pos_y_q;
  move_t         move_q;
  logic          step_q;
  logic          arrived_q;
  logic          err_q;
  err_t          code_q;
  err_t          pend_q;
  logic [7:0]    cnt_q;

  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic          oob;
  logic          at_goal;

  rat_move_step #(.CW(CW)) u_step (
    .x_i    (pos_x_q),
    .y_i    (pos_y_q),
    .move_i (move_q),
    .nx_o   (nx),
    .ny_o   (ny),
    .oob_o  (oob)
  );

  assign at_goal = (pos_x_q == GX) && (pos_y_q == GY);

  // Pop in FETCH (a move is consumed) and in DRAIN (leftovers discarded).
  assign bus.dequeue = !bus.q_empty &&
                       (((state_q == ST_FETCH) && !at_goal) || (state_q == ST_DRAIN));

`ifdef RAT_PLAYER_WALLCHK_EN
  assign bus.mem_rd = (state_q == ST_CHECK) && !oob;
  assign bus.mem_x  = bus.mem_rd ? nx : '0;
  assign bus.mem_y  = bus.mem_rd ? ny : '0;
`else
  logic unused_mem_d;
  assign unused_mem_d = bus.mem_d;
  assign bus.mem_rd   = 1'b0;
  assign bus.mem_x    = '0;
  assign bus.mem_y    = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      move_q    <= MV_RIGHT;
      step_q    <= 1'b0;
      arrived_q <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      pend_q    <= ERR_NONE;
      cnt_q     <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.run) begin
            arrived_q <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            state_q   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (at_goal) begin
            state_q <= bus.q_empty ? ST_DONE : ST_DRAIN;
          end else if (bus.q_empty) begin
            pend_q  <= ERR_DRY;
            state_q <= ST_FAULT;
          end else begin
            move_q  <= move_t'(bus.q_out);
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (oob) begin
            pend_q  <= ERR_OOB;
            state_q <= ST_FAULT;
          end else begin
`ifdef RAT_PLAYER_WALLCHK_EN
            state_q <= ST_VERIFY;
`else
            pos_x_q <= nx;
            pos_y_q <= ny;
            step_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_AFTER;
`endif
          end
        end
`ifdef RAT_PLAYER_WALLCHK_EN
        // move_q and pos are unchanged since CHECK, so nx/ny still name the read cell.
        ST_VERIFY: begin
          if (bus.mem_d) begin
            pend_q  <= ERR_WALL;
            state_q <= ST_FAULT;
          end else begin
            pos_x_q <= nx;
            pos_y_q <= ny;
            step_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_AFTER;
          end
        end
`endif
        ST_PACE: begin
          if (cnt_q == DIV_LAST) begin
            state_q <= ST_FETCH;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DRAIN: begin
          if (bus.q_empty) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          arrived_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_FAULT: begin
          err_q   <= 1'b1;
          code_q  <= pend_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.step_valid = step_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.arrived    = arrived_q;
  assign bus.err        = err_q;
  assign bus.err_code   = code_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_rat_path_player.sv
// Bench for rat_path_player: two instances (goal (2,2); STEP_DIV 0 and 4), a
// behavioural FWFT queue and maze memory per instance, and a table of replays.
module tb_rat_path_player;
  import rat_pkg::*;

`ifdef RAT_PLAYER_WALLCHK_EN
  localparam bit WCHK = 1'b1;
  localparam int PER0 = 3;
`else
  localparam bit WCHK = 1'b0;
  localparam int PER0 = 2;
`endif
  localparam int PER1 = PER0 + 4;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rat_path_player_if #(.CW(4)) if0 ();
  rat_path_player_if #(.CW(4)) if1 ();

  state_t st_v [2];

  rat_path_player #(.CW(4), .GOAL_X(2), .GOAL_Y(2), .STEP_DIV(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.master), .dbg_state_o(st_v[0]));
  rat_path_player #(.CW(4), .GOAL_X(2), .GOAL_Y(2), .STEP_DIV(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .dbg_state_o(st_v[1]));

  // Environment models: queue storage, pointers and maze walls per instance.
  logic [1:0] qmem [2][64];
  logic [5:0] qhead [2] = '{6'd0, 6'd0};
  logic [5:0] qtail [2];
  logic       maze [2][256];
  logic [1:0] run_v;
  logic [1:0] mem_d_v = 2'b00;

  logic [1:0] deq_v, rd_v, step_v, busy_v, arr_v, err_v;
  logic [3:0] px_v [2];
  logic [3:0] py_v [2];
  logic [3:0] mx_v [2];
  logic [3:0] my_v [2];
  logic [1:0] code_v [2];

  assign if0.run     = run_v[0];
  assign if0.q_out   = qmem[0][qhead[0]];
  assign if0.q_empty = (qhead[0] == qtail[0]);
  assign if0.mem_d   = mem_d_v[0];
  assign if1.run     = run_v[1];
  assign if1.q_out   = qmem[1][qhead[1]];
  assign if1.q_empty = (qhead[1] == qtail[1]);
  assign if1.mem_d   = mem_d_v[1];

  assign deq_v  = {if1.dequeue,    if0.dequeue};
  assign rd_v   = {if1.mem_rd,     if0.mem_rd};
  assign step_v = {if1.step_valid, if0.step_valid};
  assign busy_v = {if1.busy,       if0.busy};
  assign arr_v  = {if1.arrived,    if0.arrived};
  assign err_v  = {if1.err,        if0.err};
  assign px_v[0] = if0.pos_x;    assign px_v[1] = if1.pos_x;
  assign py_v[0] = if0.pos_y;    assign py_v[1] = if1.pos_y;
  assign mx_v[0] = if0.mem_x;    assign mx_v[1] = if1.mem_x;
  assign my_v[0] = if0.mem_y;    assign my_v[1] = if1.mem_y;
  assign code_v[0] = if0.err_code; assign code_v[1] = if1.err_code;

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (deq_v[g]) qhead[g] <= qhead[g] + 6'd1;
      mem_d_v[g] <= rd_v[g] ? maze[g][{my_v[g], mx_v[g]}] : 1'b0;
    end
  end

  // Scoreboard
  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         inst;
    int         n;
    logic [31:0] mv;
    logic       wall;
    logic [3:0] wx, wy;
    logic [3:0] ex, ey;
    logic       earr, eerr;
    logic [1:0] ecode;
    int         edeq, esteps, erd;
  } vec_t;

  vec_t vecs [9];

  task automatic load_queue(input int g, input int n, input logic [31:0] mv);
    qtail[g] = qhead[g];
    for (int i = 0; i < n; i++) begin
      qmem[g][qtail[g]] = (i < 16) ? mv[2*i +: 2] : 2'b00;
      qtail[g] = qtail[g] + 6'd1;
    end
  endtask

  // Expected visited cells: stop at the goal, on leaving the grid, or at a checked wall.
  task automatic model_steps(input vec_t v);
    int x, y, nx, ny;
    x = 0; y = 0;
    exp_q.delete();
    for (int i = 0; i < v.n; i++) begin
      if (x == 2 && y == 2) break;
      nx = x; ny = y;
      case (v.mv[2*i +: 2])
        2'b00: nx = x + 1;
        2'b01: ny = y + 1;
        2'b10: nx = x - 1;
        default: ny = y - 1;
      endcase
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) break;
      if (WCHK && v.wall && nx == int'(v.wx) && ny == int'(v.wy)) break;
      exp_q.push_back({4'(ny), 4'(nx)});
      x = nx; y = ny;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int g, cyc, last_step, deq, rd, steps, per;
    logic [7:0] last_addr;
    bit done;
    string nm;
    g = v.inst;
    per = (g == 0) ? PER0 : PER1;
    nm = $sformatf("v%0d", k);
    for (int i = 0; i < 256; i++) maze[g][i] = 1'b0;
    if (v.wall) maze[g][{v.wy, v.wx}] = 1'b1;
    load_queue(g, v.n, v.mv);
    model_steps(v);
    @(negedge clk);
    run_v[g] = 1'b1;
    cyc = 0; last_step = -1; deq = 0; rd = 0; steps = 0; last_addr = 8'd0; done = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        run_v[g] = 1'b0;
        check({nm, "_flags_clear"}, 32'({arr_v[g], err_v[g], code_v[g]}), 32'd0);
        check({nm, "_busy"}, 32'(busy_v[g]), 32'd1);
      end
      if (deq_v[g]) deq++;
      if (rd_v[g]) begin
        rd++;
        last_addr = {my_v[g], mx_v[g]};
      end
      if (step_v[g]) begin
        steps++;
        if (exp_q.size() == 0) begin
          check({nm, "_extra_step"}, 32'({py_v[g], px_v[g]}), 32'hFFFF_FFFF);
        end else begin
          check({nm, "_step_pos"}, 32'({py_v[g], px_v[g]}), 32'(exp_q.pop_front()));
        end
        if (last_step >= 0) check({nm, "_step_gap"}, 32'(cyc - last_step), 32'(per));
        last_step = cyc;
      end
      if (!busy_v[g]) done = 1'b1;
    end
    check({nm, "_finished"}, 32'(done), 32'd1);
    check({nm, "_pos"}, 32'({py_v[g], px_v[g]}), 32'({v.ey, v.ex}));
    check({nm, "_arrived"}, 32'(arr_v[g]), 32'(v.earr));
    check({nm, "_err"}, 32'(err_v[g]), 32'(v.eerr));
    check({nm, "_err_code"}, 32'(code_v[g]), 32'(v.ecode));
    check({nm, "_dequeues"}, 32'(deq), 32'(v.edeq));
    check({nm, "_steps"}, 32'(steps), 32'(v.esteps));
    check({nm, "_mem_rd"}, 32'(rd), 32'(v.erd));
    check({nm, "_steps_left"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_queue_left"}, 32'(6'(qtail[g] - qhead[g])), 32'd0);
    if (WCHK && v.wall) check({nm, "_mem_addr"}, 32'(last_addr), 32'({v.wy, v.wx}));
    repeat (3) @(negedge clk);
    check({nm, "_flag_hold"}, 32'({arr_v[g], err_v[g], code_v[g]}),
          32'({v.earr, v.eerr, v.ecode}));
  endtask

  initial begin
    int wait_cyc;
    rst = 1'b0;
    run_v = 2'b00;
    qtail = '{6'd0, 6'd0};
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) maze[g][i] = 1'b0;

    //              inst n   moves     wall wx    wy    ex                   ey    arr   err   code                  deq steps             rd
    vecs[0] = '{0, 4,  32'h50,  1'b0, 4'd0, 4'd0, 4'd2,                4'd2, 1'b1, 1'b0, 2'd0,                 4,  4,                WCHK ? 4 : 0};
    vecs[1] = '{0, 1,  32'h2,   1'b0, 4'd0, 4'd0, 4'd0,                4'd0, 1'b0, 1'b1, 2'd2,                 1,  0,                0};
    vecs[2] = '{0, 1,  32'h0,   1'b1, 4'd1, 4'd0, WCHK ? 4'd0 : 4'd1,  4'd0, 1'b0, 1'b1, WCHK ? 2'd1 : 2'd3,   1,  WCHK ? 0 : 1,     WCHK ? 1 : 0};
    vecs[3] = '{0, 1,  32'h0,   1'b0, 4'd0, 4'd0, 4'd1,                4'd0, 1'b0, 1'b1, 2'd3,                 1,  1,                WCHK ? 1 : 0};
    vecs[4] = '{0, 6,  32'hA50, 1'b0, 4'd0, 4'd0, 4'd2,                4'd2, 1'b1, 1'b0, 2'd0,                 6,  4,                WCHK ? 4 : 0};
    vecs[5] = '{0, 3,  32'h3D,  1'b0, 4'd0, 4'd0, 4'd0,                4'd0, 1'b0, 1'b1, 2'd2,                 3,  2,                WCHK ? 2 : 0};
    vecs[6] = '{0, 16, 32'h0,   1'b0, 4'd0, 4'd0, 4'd15,               4'd0, 1'b0, 1'b1, 2'd2,                 16, 15,               WCHK ? 15 : 0};
    vecs[7] = '{1, 4,  32'h44,  1'b0, 4'd0, 4'd0, 4'd2,                4'd2, 1'b1, 1'b0, 2'd0,                 4,  4,                WCHK ? 4 : 0};
    vecs[8] = '{0, 0,  32'h0,   1'b0, 4'd0, 4'd0, 4'd0,                4'd0, 1'b0, 1'b1, 2'd3,                 0,  0,                0};

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_outputs%0d", g),
            32'({deq_v[g], rd_v[g], step_v[g], busy_v[g], arr_v[g], err_v[g], code_v[g]}), 32'd0);
      check($sformatf("reset_pos%0d", g), 32'({py_v[g], px_v[g], my_v[g], mx_v[g]}), 32'd0);
      check($sformatf("reset_state%0d", g), 32'(st_v[g]), 32'(ST_IDLE));
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // Asynchronous reset while instance 1 is pacing after its first step.
    for (int i = 0; i < 256; i++) maze[1][i] = 1'b0;
    load_queue(1, 4, 32'h44);
    @(negedge clk);
    run_v[1] = 1'b1;
    @(negedge clk);
    run_v[1] = 1'b0;
    wait_cyc = 0;
    while (!step_v[1] && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midpace_first_step", 32'(step_v[1]), 32'd1);
    check("midpace_pos", 32'({py_v[1], px_v[1]}), 32'h10 >> 4);
    repeat (2) @(negedge clk);
    check("midpace_state", 32'(st_v[1]), 32'(ST_PACE));
    #2 rst = 1'b0;
    #1;
    check("midrst_outputs",
          32'({deq_v[1], rd_v[1], step_v[1], busy_v[1], arr_v[1], err_v[1], code_v[1]}), 32'd0);
    check("midrst_pos", 32'({py_v[1], px_v[1]}), 32'd0);
    check("midrst_state", 32'(st_v[1]), 32'(ST_IDLE));
    check("midrst_queue_kept", 32'(6'(qtail[1] - qhead[1])), 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
